entity_line_scanner: RTL and testbench

ENTITY_LINE_SCANNER -- requirements
Module: entity_line_scanner

---
 rtl/entity_line_scanner.sv | 170 +++++++++++++++++
 tb/tb_entity_line_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/entity_line_scanner.sv
// entity_line_scanner: builds one line buffer from the entity table.
// Optional macro ENTITY_CLIP_EN suppresses paint writes at column >= 480.
module entity_line_scanner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [7:0]  entities_number,
  output logic [7:0]  address_read_ent,
  input  logic [20:0] data_read_ent,
  output logic        lb_wren,
  output logic [8:0]  lb_address,
  output logic [2:0]  lb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_WAIT,
    S_TEST,
    S_PAINT,
    S_DONE
  } state_t;

  state_t      state;
  logic [8:0]  y_q;
  logic [7:0]  n_q;
  logic [7:0]  idx;
  logic [2:0]  typ_q;
  logic [5:0]  k;

  logic [9:0]  row10;
  logic [9:0]  y10;
  logic        hit;
  logic [7:0]  idx_nx;
  logic        last;
  logic [5:0]  k_nx;
  logic        en0;
  logic        en_nx;

  assign row10  = {1'b0, data_read_ent[17:9]};
  assign y10    = {1'b0, y_q};
  assign hit    = (y10 >= row10) &&
                  (y10 < row10 + 10'd48);
  assign idx_nx = idx + 8'd1;
  assign last   = (idx_nx == n_q);
  assign k_nx   = k + 6'd1;

`ifdef ENTITY_CLIP_EN
  logic [8:0] col_q;
  logic [9:0] px_nx;
  assign px_nx = {1'b0, col_q} + {4'b0, k_nx};

  // Write enables for first and next paint pixel, clipped at 480
  always_comb begin
    en0   = 1'b1;
    en_nx = 1'b1;
    en0   = ({1'b0, data_read_ent[8:0]} < 10'd480);
    en_nx = (px_nx < 10'd480);
  end
`else
  // No clipping: every paint pixel is written, address wraps in 9 bits
  always_comb begin
    en0   = 1'b1;
    en_nx = 1'b1;
  end
`endif

  // Scanner FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      y_q              <= '0;
      n_q              <= '0;
      idx              <= '0;
      typ_q            <= '0;
      k                <= '0;
      address_read_ent <= '0;
      lb_wren          <= 1'b0;
      lb_address       <= '0;
      lb_data          <= 3'b111;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef ENTITY_CLIP_EN
      col_q            <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (line_start) begin
            y_q        <= line_y;
            n_q        <= entities_number;
            idx        <= '0;
            busy       <= 1'b1;
            lb_wren    <= 1'b1;
            lb_address <= '0;
            lb_data    <= 3'b111;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (lb_address == 9'd479) begin
            lb_wren <= 1'b0;
            if (n_q == 8'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              address_read_ent <= idx;
              state            <= S_FETCH;
            end
          end else begin
            lb_address <= lb_address + 9'd1;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT:  state <= S_TEST;
        S_TEST: begin
          if (hit) begin
            typ_q      <= data_read_ent[20:18];
            k          <= '0;
            lb_wren    <= en0;
            lb_address <= data_read_ent[8:0];
            lb_data    <= data_read_ent[20:18];
            state      <= S_PAINT;
`ifdef ENTITY_CLIP_EN
            col_q      <= data_read_ent[8:0];
`endif
          end else begin
            idx <= idx_nx;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              address_read_ent <= idx_nx;
              state            <= S_FETCH;
            end
          end
        end
        S_PAINT: begin
          if (k == 6'd47) begin
            lb_wren <= 1'b0;
            idx     <= idx_nx;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              address_read_ent <= idx_nx;
              state            <= S_FETCH;
            end
          end else begin
            k          <= k_nx;
            lb_wren    <= en_nx;
            lb_address <= lb_address + 9'd1;
            lb_data    <= typ_q;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_line_scanner.sv
// tb_entity_line_scanner: scoreboard bench for entity_line_scanner.
// Expected writes and done latency are queued, a monitor pops them.
module tb_entity_line_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [8:0]  line_y;
  logic [7:0]  entities_number;
  logic [7:0]  address_read_ent;
  logic [20:0] data_read_ent;
  logic        lb_wren;
  logic [8:0]  lb_address;
  logic [2:0]  lb_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  entity_line_scanner dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .line_start       (line_start),
    .line_y           (line_y),
    .entities_number  (entities_number),
    .address_read_ent (address_read_ent),
    .data_read_ent    (data_read_ent),
    .lb_wren          (lb_wren),
    .lb_address       (lb_address),
    .lb_data          (lb_data),
    .busy             (busy),
    .done             (done)
  );

  logic [20:0] mem [0:255];
  logic [2:0]  lbuf [0:511];

  always @(posedge clk) data_read_ent <= mem[address_read_ent];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;
  int wq[$];
  int lq[$];
  int start_cyc = 0;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] ent(int t, int r, int c);
    logic [20:0] e;
    e = {t[2:0], r[8:0], c[8:0]};
    return e;
  endfunction

  task automatic push_clear();
    for (int i = 0; i < 480; i++) wq.push_back(i * 8 + 7);
  endtask

  task automatic push_paint(int col, int t);
    for (int k = 0; k < 48; k++) begin
      int p;
      bit keep;
      p = col + k;
      keep = 1'b1;
`ifdef ENTITY_CLIP_EN
      keep = (p < 480);
`endif
      if (keep) wq.push_back((p % 512) * 8 + t);
    end
  endtask

  task automatic start(int y, int n, int lat);
    @(negedge clk);
    line_y = y[8:0];
    entities_number = n[7:0];
    line_start = 1'b1;
    start_cyc = cyc + 1;
    lq.push_back(lat);
    @(negedge clk);
    line_start = 1'b0;
    chk("busy_set", int'(busy), 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      wq.delete();
      lq.delete();
    end
    repeat (3) @(negedge clk);
    chk("writes_left", wq.size(), 0);
  endtask

  // Monitor: pop expected write per lb_wren, latency per done
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en && lb_wren) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", int'(lb_address), -1);
        end else begin
          chk("write", int'({lb_address, lb_data}), wq.pop_front());
        end
      end
      if (lb_wren) lbuf[lb_address] = lb_data;
      if (chk_en && done) begin
        if (lq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("latency", cyc - start_cyc + 1, lq.pop_front());
        end
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    line_start = 1'b0;
    line_y = '0;
    entities_number = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wren", int'(lb_wren), 0);
    chk("rst_addr", int'(address_read_ent), 0);
    chk("rst_lbaddr", int'(lb_address), 0);
    chk("rst_lbdata", int'(lb_data), 7);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // N=0: clear only
    push_clear();
    start(10, 0, 481);
    wait_done();

    // N=1 hit, with ignored line_start while busy
    mem[0] = ent(3, 48, 96);
    push_clear();
    push_paint(96, 3);
    start(60, 1, 532);
    repeat (10) @(negedge clk);
    line_y = 9'd200;
    entities_number = 8'd0;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    wait_done();
    chk("c_lb95", int'(lbuf[95]), 7);
    chk("c_lb96", int'(lbuf[96]), 3);
    chk("c_lb143", int'(lbuf[143]), 3);
    chk("c_lb144", int'(lbuf[144]), 7);

    // N=1 miss at y = row+48
    push_clear();
    start(96, 1, 484);
    wait_done();

    // Painter's order
    mem[0] = ent(0, 0, 0);
    mem[1] = ent(2, 0, 24);
    push_clear();
    push_paint(0, 0);
    push_paint(24, 2);
    start(5, 2, 583);
    wait_done();
    chk("e_lb23", int'(lbuf[23]), 0);
    chk("e_lb24", int'(lbuf[24]), 2);
    chk("e_lb71", int'(lbuf[71]), 2);
    chk("e_lb72", int'(lbuf[72]), 7);

    // Wrapped row miss, low and high row boundaries hit
    mem[0] = ent(1, 500, 0);
    mem[1] = ent(5, 100, 200);
    mem[2] = ent(6, 53, 300);
    push_clear();
    push_paint(200, 5);
    push_paint(300, 6);
    start(100, 3, 586);
    wait_done();

    // Right edge at col 460
    mem[0] = ent(4, 0, 460);
    push_clear();
    push_paint(460, 4);
    start(0, 1, 532);
    wait_done();

    // Column wrap at col 500
    mem[0] = ent(4, 0, 500);
    push_clear();
    push_paint(500, 4);
    start(0, 1, 532);
    wait_done();
`ifdef ENTITY_CLIP_EN
    chk("h_lb0", int'(lbuf[0]), 7);
`else
    chk("h_lb0", int'(lbuf[0]), 4);
`endif

    // Reset during PAINT of entity 0
    mem[0] = ent(3, 48, 96);
    chk_en = 1'b0;
    start(60, 1, 532);
    while (cyc < start_cyc + 489) @(negedge clk);
    chk("pre_rst_wren", int'(lb_wren), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wren", int'(lb_wren), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_addr", int'(address_read_ent), 0);
    chk("mid_rst_lbaddr", int'(lb_address), 0);
    chk("mid_rst_lbdata", int'(lb_data), 7);
    rst_n = 1'b1;
    wq.delete();
    lq.delete();
    chk_en = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    chk("idle_busy", int'(busy), 0);

    // Fresh line after reset
    push_clear();
    push_paint(96, 3);
    start(60, 1, 532);
    wait_done();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
